// File: rtl/slow_clock_monitor.sv
// Brings the divided slow game clock back into the 120 kHz domain, ticks on its
// rising edges, measures the period and tracks lock / sticky frequency faults.
`timescale 1ns/1ps

module slow_clock_monitor #(
    parameter int unsigned NOMINAL_PERIOD = 10000,
    parameter int unsigned TOLERANCE      = 100,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned CNT_W          = 14
) (
    input  logic             clk_120kHz,
    input  logic             rstn,
    input  logic             enable,
    input  logic             slow_clk_in,
    input  logic             clr_fault,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_fast,
    output logic             err_slow
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] PERIOD_LO   = CNT_W'(NOMINAL_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0] PERIOD_HI   = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(NOMINAL_PERIOD + TOLERANCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic                   tick_q, tick_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   err_fast_q, err_fast_d;
    logic                   err_slow_q, err_slow_d;

    logic rise_c;
    logic short_c;
    logic long_c;
    logic in_range_c;
    logic timeout_c;

    // Synchroniser and edge flop run regardless of enable so no stale edge appears later.
    always_ff @(posedge clk_120kHz or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c     = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign short_c    = (cnt_q < PERIOD_LO);
    assign long_c     = (cnt_q > PERIOD_HI);
    assign in_range_c = ~short_c & ~long_c;
    assign timeout_c  = ~rise_c & (cnt_q == TIMEOUT_CNT);

    // State and registered outputs.
    always_ff @(posedge clk_120kHz or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            tick_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_fast_q     <= 1'b0;
            err_slow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            tick_q         <= tick_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_fast_q     <= err_fast_d;
            err_slow_q     <= err_slow_d;
        end
    end

    // Next-state, period measurement and fault flags; a set in the same cycle as clr_fault wins.
    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        good_d         = good_q;
        tick_d         = 1'b0;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_fast_d     = err_fast_q;
        err_slow_d     = err_slow_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else begin
            tick_d = rise_c;
            if (clr_fault) begin
                err_fast_d = 1'b0;
                err_slow_d = 1'b0;
            end
            if (rise_c) begin
                cnt_d = CNT_W'(1);
                if (state_q != IDLE) begin
                    period_valid_d = 1'b1;
                    period_d       = cnt_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (rise_c) begin
                        if (in_range_c) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_d == GOOD_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end else if (timeout_c) begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (rise_c) begin
                        if (short_c) begin
                            err_fast_d = 1'b1;
                            state_d    = FAULT;
                        end else if (long_c) begin
                            err_slow_d = 1'b1;
                            state_d    = FAULT;
                        end
                    end else if (timeout_c) begin
                        err_slow_d = 1'b1;
                        state_d    = FAULT;
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_fast     = err_fast_q;
    assign err_slow     = err_slow_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor: scaled-down periods, directed scenarios plus random
// periods, compared each cycle against a period-arithmetic reference model.
`timescale 1ns/1ps

module tb_slow_clock_monitor;

    localparam int unsigned NOM   = 200;
    localparam int unsigned TOL   = 10;
    localparam int unsigned LOCKN = 4;
    localparam int unsigned SS    = 2;
    localparam int unsigned CW    = 9;
    localparam int LO   = NOM - TOL;
    localparam int HI   = NOM + TOL;
    localparam int TO   = HI + 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          slow_in = 1'b0;
    logic          clr = 1'b0;
    logic          tick;
    logic [CW-1:0] period;
    logic          pv;
    logic          locked;
    logic          ef;
    logic          es;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slow_clock_monitor #(
        .NOMINAL_PERIOD(NOM),
        .TOLERANCE     (TOL),
        .LOCK_COUNT    (LOCKN),
        .SYNC_STAGES   (SS),
        .CNT_W         (CW)
    ) dut (
        .clk_120kHz  (clk),
        .rstn        (rstn),
        .enable      (enable),
        .slow_clk_in (slow_in),
        .clr_fault   (clr),
        .tick        (tick),
        .period      (period),
        .period_valid(pv),
        .locked      (locked),
        .err_fast    (ef),
        .err_slow    (es)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 acquiring, 2 locked, 3 fault; periods from edge indices.
    bit  hist[$];
    int  cyc, last_rise, mode, good;
    bit  e_tick, e_pv, e_locked, e_ef, e_es;
    int  e_period;

    always @(posedge clk or negedge rstn) begin
        bit rise, to, inr;
        int s, d, meas;
        if (!rstn) begin
            hist.delete();
            cyc = 0; last_rise = 0; mode = 0; good = 0;
            e_tick = 0; e_pv = 0; e_locked = 0; e_ef = 0; e_es = 0; e_period = 0;
        end else begin
            cyc++;
            hist.push_back(slow_in);
            if (hist.size() > 8) void'(hist.pop_front());
            s    = hist.size();
            rise = (s >= 3 && hist[s-3]) && !(s >= 4 && hist[s-4]);
            d    = cyc - last_rise;
            meas = (d > MAXC) ? MAXC : d;
            inr  = (meas >= LO) && (meas <= HI);
            to   = !rise && (d == TO);
            if (!enable) begin
                mode = 0; good = 0; e_tick = 0; e_pv = 0;
            end else begin
                e_tick = rise;
                e_pv   = 0;
                if (clr) begin e_ef = 0; e_es = 0; end
                if (rise && mode != 0) begin e_pv = 1; e_period = meas; end
                case (mode)
                    0: if (rise) begin mode = 1; good = 0; end
                    1: begin
                        if (rise) begin
                            if (inr) begin
                                good++;
                                if (good >= LOCKN) mode = 2;
                            end else good = 0;
                        end else if (to) mode = 0;
                    end
                    2: begin
                        if (rise && meas < LO) begin e_ef = 1; mode = 3; end
                        else if (rise && meas > HI) begin e_es = 1; mode = 3; end
                        else if (to) begin e_es = 1; mode = 3; end
                    end
                    default: if (clr) mode = 0;
                endcase
                if (rise) last_rise = cyc;
            end
            e_locked = (mode == 2);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("tick", tick, e_tick);
        chk("period_valid", pv, e_pv);
        chk("period", int'(period), e_period);
        chk("locked", locked, e_locked);
        chk("err_fast", ef, e_ef);
        chk("err_slow", es, e_es);
    end

    // Distance from last tick to err_slow rising, for the timeout check.
    int  ncyc = 0, last_tick_cyc = 0, es_rise_cyc = 0;
    bit  es_prev = 0;
    always @(negedge clk) begin
        ncyc++;
        if (tick) last_tick_cyc = ncyc;
        if (es && !es_prev) es_rise_cyc = ncyc;
        es_prev = es;
    end

    task automatic run_period(input int p, input int hi, input int clr_at);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            slow_in = (i < hi);
            clr     = (i == clr_at);
        end
    endtask

    task automatic idle_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            slow_in = 1'b0;
            clr     = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic lock_up();
        repeat (6) run_period(NOM, NOM / 2, -1);
    endtask

    initial begin
        int p, hi, ca;
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_period", int'(period), 0);
        rstn = 1'b1;
        enable = 1'b1;
        idle_low(5);

        // clean input locks on the 5th tick
        lock_up();
        chk("lock1_locked", locked, 1);
        chk("lock1_period", int'(period), NOM);
        chk("lock1_errs", {ef, es}, 0);

        // one short period while locked
        run_period(180, 90, -1);
        run_period(NOM, NOM / 2, -1);
        chk("fast_err", ef, 1);
        chk("fast_locked", locked, 0);
        chk("fast_period", int'(period), 180);

        pulse_clr();
        lock_up();
        chk("relock_locked", locked, 1);
        chk("relock_err_fast", ef, 0);

        // input stuck low while locked: timeout
        idle_low(300);
        chk("timeout_err_slow", es, 1);
        chk("timeout_locked", locked, 0);
        chk("timeout_dist", es_rise_cyc - last_tick_cyc, TO);

        // counter saturation reported on the next edge
        idle_low(600);
        run_period(NOM, NOM / 2, -1);
        chk("sat_period", int'(period), MAXC);

        pulse_clr();
        chk("clr_err_slow", es, 0);

        // acquire with boundary periods
        run_period(LO, 90, -1);
        run_period(HI, 90, -1);
        run_period(LO - 1, 90, -1);
        repeat (4) run_period(NOM, NOM / 2, -1);
        chk("acq_not_locked", locked, 0);
        chk("acq_errs", {ef, es}, 0);
        run_period(NOM, NOM / 2, -1);
        chk("acq_locked", locked, 1);

        // clr_fault in the same cycle as a short-period edge
        run_period(180, 90, -1);
        run_period(NOM, NOM / 2, 2);
        chk("setwins_err_fast", ef, 1);
        chk("setwins_locked", locked, 0);

        // enable low holds flags and period
        pulse_clr();
        lock_up();
        run_period(180, 90, -1);
        run_period(NOM, NOM / 2, -1);
        @(negedge clk); enable = 1'b0;
        repeat (2) run_period(NOM, NOM / 2, -1);
        chk("dis_err_fast", ef, 1);
        chk("dis_period", int'(period), 180);
        @(negedge clk); enable = 1'b1;
        lock_up();
        chk("en_relock", locked, 1);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        chk("dis_locked", locked, 0);
        run_period(NOM, NOM / 2, -1);
        chk("dis_err_held", ef, 1);
        @(negedge clk); enable = 1'b1;

        // reset in the middle of acquisition
        pulse_clr();
        repeat (2) run_period(NOM, NOM / 2, -1);
        @(negedge clk); slow_in = 1'b1;
        repeat (40) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_tick", tick, 0);
        chk("rst_mid_pv", pv, 0);
        chk("rst_mid_period", int'(period), 0);
        chk("rst_mid_locked", locked, 0);
        chk("rst_mid_err", {ef, es}, 0);
        @(negedge clk); rstn = 1'b1; slow_in = 1'b0;

        // random periods, gaps, clears and enable drops
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 3) == 0) p = NOM - 30 + int'($urandom_range(0, 60));
            else                           p = NOM - TOL + int'($urandom_range(0, 2 * TOL));
            hi = int'($urandom_range(1, p - 1));
            ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, p - 1)) : -1;
            run_period(p, hi, ca);
            if ($urandom_range(0, 11) == 0) idle_low(int'($urandom_range(150, 700)));
            if ($urandom_range(0, 14) == 0) begin
                @(negedge clk); enable = 1'b0;
                run_period(NOM, int'($urandom_range(1, NOM - 1)), -1);
                @(negedge clk); enable = 1'b1;
            end
        end
        idle_low(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
